// File: rtl/mips_mem_port_master.sv
// rtl/mips_mem_port_master.sv - core-side master for one port of the word-wide synchronous memory.
// Optional MIPS_MEM_ALIGN_CHECK_EN turns misaligned half/word requests into errors instead of aligning them down.
module mips_mem_port_master #(
    parameter int          N          = 32,
    parameter logic [31:0] ADDR_LIMIT = 32'd2052
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [1:0]   req_size,
    input  logic         req_signed,
    input  logic [N-1:0] req_addr,
    input  logic [N-1:0] req_wdata,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [N-1:0] resp_rdata,
    output logic         resp_err,
    output logic         mem_wr_ena,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wr_data,
    input  logic [N-1:0] mem_rd_data
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CHECK    = 3'd1;
    localparam logic [2:0] S_ERR      = 3'd2;
    localparam logic [2:0] S_RD_ISSUE = 3'd3;
    localparam logic [2:0] S_RD_CAPT  = 3'd4;
    localparam logic [2:0] S_WR       = 3'd5;
    localparam logic [2:0] S_RESP     = 3'd6;

    logic [2:0]   state_q, state_d;
    logic         we_q, we_d;
    logic [1:0]   size_q, size_d;
    logic         signed_q, signed_d;
    logic [N-1:0] addr_q, addr_d;
    logic [N-1:0] wdata_q, wdata_d;
    logic [N-1:0] resp_rdata_q, resp_rdata_d;
    logic         resp_err_q, resp_err_d;
    logic [N-1:0] mem_addr_q, mem_addr_d;
    logic [N-1:0] mem_wr_data_q, mem_wr_data_d;

    logic         err_c;
    logic [N-1:0] eff_addr;
    logic [N-1:0] word_addr;
    logic [1:0]   lane;
    logic [7:0]   rd_byte;
    logic [15:0]  rd_half;
    logic [N-1:0] load_fmt;
    logic [N-1:0] merged;

    // Request decode: error detection, effective address, load formatting and RMW merge.
    always_comb begin
        err_c    = (size_q == 2'b11) || (addr_q >= ADDR_LIMIT);
        eff_addr = addr_q;
`ifdef MIPS_MEM_ALIGN_CHECK_EN
        if (size_q == 2'b01 && addr_q[0]) err_c = 1'b1;
        if (size_q == 2'b10 && addr_q[1:0] != 2'b00) err_c = 1'b1;
`else
        if (size_q == 2'b01) eff_addr[0] = 1'b0;
        if (size_q == 2'b10) eff_addr[1:0] = 2'b00;
`endif
        lane      = eff_addr[1:0];
        word_addr = {eff_addr[N-1:2], 2'b00};
        rd_byte   = mem_rd_data[{lane, 3'b000} +: 8];
        rd_half   = mem_rd_data[{lane[1], 4'b0000} +: 16];

        case (size_q)
            2'b00:   load_fmt = signed_q ? {{(N-8){rd_byte[7]}}, rd_byte} : {{(N-8){1'b0}}, rd_byte};
            2'b01:   load_fmt = signed_q ? {{(N-16){rd_half[15]}}, rd_half} : {{(N-16){1'b0}}, rd_half};
            default: load_fmt = mem_rd_data;
        endcase

        merged = mem_rd_data;
        case (size_q)
            2'b00:   merged[{lane, 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   merged[{lane[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        size_d        = size_q;
        signed_d      = signed_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        resp_rdata_d  = resp_rdata_q;
        resp_err_d    = resp_err_q;
        mem_addr_d    = mem_addr_q;
        mem_wr_data_d = mem_wr_data_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (err_c) begin
                    state_d = S_ERR;
                end else if (we_q && size_q == 2'b10) begin
                    mem_addr_d    = word_addr;
                    mem_wr_data_d = wdata_q;
                    state_d       = S_WR;
                end else begin
                    mem_addr_d = word_addr;
                    state_d    = S_RD_ISSUE;
                end
            end
            S_RD_ISSUE: state_d = S_RD_CAPT;
            S_RD_CAPT: begin
                // Read data is valid here, one cycle after the address was presented.
                if (we_q) begin
                    mem_wr_data_d = merged;
                    state_d       = S_WR;
                end else begin
                    resp_rdata_d = load_fmt;
                    resp_err_d   = 1'b0;
                    state_d      = S_RESP;
                end
            end
            S_WR: begin
                resp_rdata_d = '0;
                resp_err_d   = 1'b0;
                state_d      = S_RESP;
            end
            S_ERR: begin
                resp_rdata_d = '0;
                resp_err_d   = 1'b1;
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q       <= S_IDLE;
            we_q          <= 1'b0;
            size_q        <= 2'b00;
            signed_q      <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            resp_rdata_q  <= '0;
            resp_err_q    <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            size_q        <= size_d;
            signed_q      <= signed_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_err_q    <= resp_err_d;
            mem_addr_q    <= mem_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign resp_valid  = (state_q == S_RESP);
    assign mem_wr_ena  = (state_q == S_WR);
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wr_data = mem_wr_data_q;

endmodule

// File: tb/tb_mips_mem_port_master.sv
// tb/tb_mips_mem_port_master.sv - directed bench with a behavioural memory/response model for mips_mem_port_master.
module tb_mips_mem_port_master;

    logic        clk;
    logic        rstb;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_wr_ena;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;

    int vectors;
    int miscompares;
    int wr_pulses;
    logic        mem_clear;
    logic [31:0] mem     [0:512];
    logic [31:0] ref_mem [0:512];
    logic [31:0] exp_rdata;
    logic        exp_err;

`ifdef MIPS_MEM_ALIGN_CHECK_EN
    localparam logic [31:0] W10_AFTER_HALF = 32'hDEADA5EF;
`else
    localparam logic [31:0] W10_AFTER_HALF = 32'h1234A5EF;
`endif

    mips_mem_port_master dut (
        .clk         (clk),
        .rstb        (rstb),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mem_wr_ena  (mem_wr_ena),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: registered read, write on the edge where wr_ena is high.
    wire [29:0] widx = mem_addr[31:2];
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 513; i++) mem[i] <= 32'h0;
            mem_rd_data <= 32'h0;
        end else begin
            if (mem_wr_ena && widx < 30'd513) mem[widx] <= mem_wr_data;
            mem_rd_data <= (widx < 30'd513) ? mem[widx] : 32'h0;
        end
    end

    always @(posedge clk or negedge rstb) begin
        if (!rstb) wr_pulses <= wr_pulses;
        else if (mem_wr_ena) wr_pulses <= wr_pulses + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (rstb && resp_valid) begin
            check("resp_rdata", resp_rdata, exp_rdata);
            check("resp_err", {31'b0, resp_err}, {31'b0, exp_err});
            check("req_ready_in_resp", {31'b0, req_ready}, 32'h0);
        end
        if (rstb && mem_wr_ena) check("mem_addr_aligned", {30'b0, mem_addr[1:0]}, 32'h0);
    end

    task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output logic err, output int lat, output int nwr);
        logic [31:0] a;
        logic [31:0] w;
        int sh;
        int idx;
        bit align;
`ifdef MIPS_MEM_ALIGN_CHECK_EN
        align = 1'b1;
`else
        align = 1'b0;
`endif
        err = (size == 2'b11) || (addr >= 32'd2052) ||
              (align && ((size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00)));
        rd = 32'h0;
        lat = 2;
        nwr = 0;
        if (!err) begin
            a = addr;
            if (size == 2'b01) a[0] = 1'b0;
            if (size == 2'b10) a[1:0] = 2'b00;
            idx = int'(a >> 2);
            sh = int'(a[1:0]) * 8;
            w = ref_mem[idx];
            if (!we) begin
                lat = 3;
                if (size == 2'b00) begin
                    rd = (w >> sh) & 32'hFF;
                    if (sgn && rd >= 32'd128) rd = rd | 32'hFFFFFF00;
                end else if (size == 2'b01) begin
                    rd = (w >> sh) & 32'hFFFF;
                    if (sgn && rd >= 32'h8000) rd = rd | 32'hFFFF0000;
                end else begin
                    rd = w;
                end
            end else begin
                nwr = 1;
                lat = (size == 2'b10) ? 2 : 4;
                if (size == 2'b00) w = (w & ~(32'hFF << sh)) | ((wdata & 32'hFF) << sh);
                else if (size == 2'b01) w = (w & ~(32'hFFFF << sh)) | ((wdata & 32'hFFFF) << sh);
                else w = wdata;
                ref_mem[idx] = w;
            end
        end
    endtask

    // Called at a negedge; returns at a negedge after the response completes.
    task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int hold, input bit b2b,
                           output logic [31:0] got_rdata, output logic got_err);
        int lat;
        int wr0;
        int exp_lat;
        int exp_wr;
        logic [31:0] er;
        logic ee;
        model(we, size, sgn, addr, wdata, er, ee, exp_lat, exp_wr);
        check("req_ready_idle", {31'b0, req_ready}, 32'h1);
        wr0 = wr_pulses;
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        exp_rdata = er;
        exp_err = ee;
        lat = 0;
        forever begin
            @(negedge clk);
            req_valid = 1'b0;
            if (resp_valid || lat >= 20) break;
            @(posedge clk);
            lat++;
        end
        check("latency", lat, exp_lat);
        for (int i = 0; i < hold; i++) begin
            if (i == 2) begin
                req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h10; req_wdata = 32'h0;
            end
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
            check("req_ready_held", {31'b0, req_ready}, 32'h0);
            check("resp_valid_held", {31'b0, resp_valid}, 32'h1);
        end
        got_rdata = resp_rdata;
        got_err = resp_err;
        resp_ready = 1'b1;
        if (b2b) req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        check("resp_valid_after", {31'b0, resp_valid}, 32'h0);
        check("req_ready_after", {31'b0, req_ready}, 32'h1);
        check("wr_pulses", wr_pulses - wr0, exp_wr);
        if (addr < 32'd2052) check("mem_word", mem[addr >> 2], ref_mem[addr >> 2]);
    endtask

    logic [31:0] rd;
    logic        er;
    int          wr_before;

    initial begin
        vectors = 0; miscompares = 0; wr_pulses = 0;
        exp_rdata = 32'h0; exp_err = 1'b0;
        for (int i = 0; i < 513; i++) ref_mem[i] = 32'h0;
        rstb = 1'b0; mem_clear = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
        #1;
        check("rst_req_ready", {31'b0, req_ready}, 32'h1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        check("rst_mem_wr_ena", {31'b0, mem_wr_ena}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        mem_clear = 1'b0; rstb = 1'b1;

        // 1: word store then word load
        run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0, 1'b0, rd, er);
        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, 1'b0, rd, er);
        check("lit_load_word", rd, 32'hDEADBEEF);
        // 2: byte RMW and sub-word loads
        run_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000A5, 0, 1'b0, rd, er);
        check("lit_rmw_word", mem[4], 32'hDEADA5EF);
        run_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 0, 1'b0, rd, er);
        check("lit_sbyte", rd, 32'hFFFFFFA5);
        run_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 0, 1'b0, rd, er);
        check("lit_ubyte", rd, 32'h000000A5);
        run_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 0, 1'b0, rd, er);
        check("lit_shalf", rd, 32'hFFFFDEAD);
        // 3: misaligned half store
        run_req(1'b1, 2'b01, 1'b0, 32'h13, 32'h00001234, 0, 1'b0, rd, er);
        check("lit_half_store_word", mem[4], W10_AFTER_HALF);
        run_req(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 0, 1'b0, rd, er);
        // 4: range and size boundaries
        run_req(1'b1, 2'b10, 1'b0, 32'h800, 32'hCAFEF00D, 0, 1'b0, rd, er);
        run_req(1'b0, 2'b10, 1'b0, 32'h800, 32'h0, 0, 1'b0, rd, er);
        check("lit_load_2048", rd, 32'hCAFEF00D);
        run_req(1'b0, 2'b10, 1'b0, 32'h804, 32'h0, 0, 1'b0, rd, er);
        check("lit_err_2052", {31'b0, er}, 32'h1);
        run_req(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 0, 1'b0, rd, er);
        check("lit_err_size", {31'b0, er}, 32'h1);
        // 5: held response with ignored request, then back-to-back accept
        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5, 1'b1, rd, er);
        check("lit_held_rdata", rd, W10_AFTER_HALF);
        run_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 0, 1'b0, rd, er);
        check("lit_byte0", rd, 32'h000000EF);
        // 6: reset during RD_CAPT of a byte store
        wr_before = wr_pulses;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h11; req_wdata = 32'h5A;
        @(posedge clk);
        @(negedge clk); req_valid = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rstb = 1'b0;
        #1;
        check("abort_req_ready", {31'b0, req_ready}, 32'h1);
        check("abort_resp_valid", {31'b0, resp_valid}, 32'h0);
        check("abort_resp_err", {31'b0, resp_err}, 32'h0);
        check("abort_resp_rdata", resp_rdata, 32'h0);
        check("abort_mem_wr_ena", {31'b0, mem_wr_ena}, 32'h0);
        check("abort_mem_addr", mem_addr, 32'h0);
        check("abort_mem_wr_data", mem_wr_data, 32'h0);
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rstb = 1'b1;
        check("abort_no_write", wr_pulses - wr_before, 0);
        check("abort_mem_word", mem[4], W10_AFTER_HALF);
        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, 1'b0, rd, er);
        check("lit_after_abort", rd, W10_AFTER_HALF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
